// File: rtl/tof_ping_scheduler.sv
// Round-robin ultrasonic ping sequencer with emission timestamping and per-receiver first-arrival capture.
// Optional macro TOF_SCHED_IRQ_EN enables ping_done_irq and the CTRL[2] irq_clear bit.
module tof_ping_scheduler #(
    parameter int N_TX         = 4,
    parameter int N_RX         = 4,
    parameter int PULSE_CYCLES = 16,
    parameter int BLANK_CYCLES = 64
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       time_cnt,
    input  logic [N_RX-1:0]   rx_event,
    input  logic [7:0]        avalon_slave_address,
    input  logic              avalon_slave_write,
    input  logic [31:0]       avalon_slave_writedata,
    input  logic              avalon_slave_read,
    output logic [31:0]       avalon_slave_readdata,
    output logic              avalon_slave_waitrequest,
    output logic [N_TX-1:0]   piezo_enable,
    output logic              ping_done_irq
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_EMIT   = 3'd2;
    localparam logic [2:0] S_BLANK  = 3'd3;
    localparam logic [2:0] S_LISTEN = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_GAP    = 3'd6;

    localparam logic [31:0] PULSE_LD = 32'(PULSE_CYCLES - 1);
    localparam logic [31:0] BLANK_LD = 32'(BLANK_CYCLES - 1);

    logic [2:0]      state_q, state_d;
    logic [2:0]      cur_tx_q, cur_tx_d;
    logic [15:0]     seq_q, seq_d;
    logic            run_q, run_d;
    logic            single_q, single_d;
    logic [N_TX-1:0] mask_q, mask_d;
    logic [31:0]     period_q, period_d;
    logic [31:0]     timeout_q, timeout_d;
    logic [31:0]     emit_time_q, emit_time_d;
    logic [N_RX-1:0] rx_valid_q, rx_valid_d;
    logic [31:0]     rx_delta_q [N_RX];
    logic [31:0]     rx_delta_d [N_RX];
    logic [31:0]     cnt_q, cnt_d;
    logic [31:0]     since_q, since_d;
    logic [N_RX-1:0] rx_s1_q, rx_s2_q, rx_s3_q;
    logic [N_TX-1:0] piezo_q, piezo_d;
    logic            irq_q, irq_d;
    logic            rd_pend_q, rd_pend_d;
    logic [31:0]     readdata_q, readdata_d;

    logic [2:0]      next_tx;
    logic            tx_found;
    logic [N_RX-1:0] rx_rise;
    logic            timeout_hit;
    logic            ctrl_wr;
    logic [31:0]     rd_mux;
    int              idx;

    assign rx_rise     = rx_s2_q & ~rx_s3_q;
    assign timeout_hit = (cnt_q + 32'd1 == timeout_q) || (timeout_q == 32'd0);
    assign ctrl_wr     = avalon_slave_write && (avalon_slave_address == 8'h00);

    // Round-robin search starts one past cur_tx and wraps back onto cur_tx last.
    always_comb begin
        next_tx  = cur_tx_q;
        tx_found = 1'b0;
        idx      = 0;
        for (int i = 1; i <= N_TX; i++) begin
            idx = int'(cur_tx_q) + i;
            if (idx >= N_TX) idx = idx - N_TX;
            if (!tx_found && mask_q[idx]) begin
                tx_found = 1'b1;
                next_tx  = 3'(idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cur_tx_d    = cur_tx_q;
        seq_d       = seq_q;
        run_d       = run_q;
        single_d    = single_q;
        mask_d      = mask_q;
        period_d    = period_q;
        timeout_d   = timeout_q;
        emit_time_d = emit_time_q;
        rx_valid_d  = rx_valid_q;
        rx_delta_d  = rx_delta_q;
        cnt_d       = cnt_q;
        since_d     = (since_q == 32'hFFFF_FFFF) ? since_q : since_q + 32'd1;
        irq_d       = irq_q;

        case (state_q)
            S_IDLE: begin
                if (run_q || single_q) begin
                    state_d  = S_SELECT;
                    single_d = 1'b0;
                end
            end
            S_SELECT: begin
                rx_valid_d = '0;
                for (int r = 0; r < N_RX; r++) rx_delta_d[r] = 32'hFFFF_FFFF;
                if (tx_found) begin
                    state_d     = S_EMIT;
                    cur_tx_d    = next_tx;
                    cnt_d       = PULSE_LD;
                    since_d     = 32'd0;
                    emit_time_d = time_cnt;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EMIT: begin
                if (cnt_q == 32'd0) begin
                    if (BLANK_CYCLES == 0) begin
                        state_d = S_LISTEN;
                        cnt_d   = 32'd0;
                    end else begin
                        state_d = S_BLANK;
                        cnt_d   = BLANK_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_BLANK: begin
                if (cnt_q == 32'd0) begin
                    state_d = S_LISTEN;
                    cnt_d   = 32'd0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            S_LISTEN: begin
                for (int r = 0; r < N_RX; r++) begin
                    if (rx_rise[r] && !rx_valid_q[r]) begin
                        rx_valid_d[r] = 1'b1;
                        rx_delta_d[r] = time_cnt - emit_time_q;
                    end
                end
                cnt_d = cnt_q + 32'd1;
                if ((&rx_valid_d) || timeout_hit) state_d = S_DONE;
            end
            S_DONE: begin
                seq_d   = seq_q + 16'd1;
                state_d = S_GAP;
            end
            S_GAP: begin
                // since_q counts edges from EMIT entry; +2 covers this cycle and SELECT.
                if ({1'b0, since_q} + 33'd2 >= {1'b0, period_q})
                    state_d = run_q ? S_SELECT : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (avalon_slave_write) begin
            case (avalon_slave_address)
                8'h00: begin
                    run_d = avalon_slave_writedata[0];
                    if (avalon_slave_writedata[1]) single_d = 1'b1;
                end
                8'h01: mask_d    = avalon_slave_writedata[N_TX-1:0];
                8'h02: period_d  = avalon_slave_writedata;
                8'h03: timeout_d = avalon_slave_writedata;
                default: ;
            endcase
        end

`ifdef TOF_SCHED_IRQ_EN
        if (ctrl_wr && avalon_slave_writedata[2]) irq_d = 1'b0;
        if (state_q == S_DONE) irq_d = 1'b1;
`else
        irq_d = 1'b0;
`endif

        for (int t = 0; t < N_TX; t++)
            piezo_d[t] = (state_d == S_EMIT) && (cur_tx_d == 3'(t));
    end

    always_comb begin
        rd_mux = 32'hDEAD_BEEF;
        case (avalon_slave_address)
            8'h00: rd_mux = {31'd0, run_q};
            8'h01: rd_mux = 32'(mask_q);
            8'h02: rd_mux = period_q;
            8'h03: rd_mux = timeout_q;
            8'h04: rd_mux = {seq_q, 5'd0, cur_tx_q, 5'd0, state_q};
            8'h05: rd_mux = emit_time_q;
            8'h06: rd_mux = 32'(rx_valid_q);
            default: begin
                for (int r = 0; r < N_RX; r++)
                    if (avalon_slave_address == 8'(8 + r)) rd_mux = rx_delta_q[r];
            end
        endcase
        rd_pend_d  = avalon_slave_read && !rd_pend_q;
        readdata_d = rd_pend_d ? rd_mux : readdata_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cur_tx_q    <= '0;
            seq_q       <= '0;
            run_q       <= 1'b0;
            single_q    <= 1'b0;
            mask_q      <= '0;
            period_q    <= '0;
            timeout_q   <= 32'h0000_FFFF;
            emit_time_q <= '0;
            rx_valid_q  <= '0;
            for (int r = 0; r < N_RX; r++) rx_delta_q[r] <= 32'hFFFF_FFFF;
            cnt_q       <= '0;
            since_q     <= '0;
            rx_s1_q     <= '0;
            rx_s2_q     <= '0;
            rx_s3_q     <= '0;
            piezo_q     <= '0;
            irq_q       <= 1'b0;
            rd_pend_q   <= 1'b0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cur_tx_q    <= cur_tx_d;
            seq_q       <= seq_d;
            run_q       <= run_d;
            single_q    <= single_d;
            mask_q      <= mask_d;
            period_q    <= period_d;
            timeout_q   <= timeout_d;
            emit_time_q <= emit_time_d;
            rx_valid_q  <= rx_valid_d;
            rx_delta_q  <= rx_delta_d;
            cnt_q       <= cnt_d;
            since_q     <= since_d;
            rx_s1_q     <= rx_event;
            rx_s2_q     <= rx_s1_q;
            rx_s3_q     <= rx_s2_q;
            piezo_q     <= piezo_d;
            irq_q       <= irq_d;
            rd_pend_q   <= rd_pend_d;
            readdata_q  <= readdata_d;
        end
    end

    assign piezo_enable             = piezo_q;
    assign ping_done_irq            = irq_q;
    assign avalon_slave_readdata    = readdata_q;
    assign avalon_slave_waitrequest = avalon_slave_read && !rd_pend_q;

endmodule

// File: tb/tb_tof_ping_scheduler.sv
// Directed bench for tof_ping_scheduler: register map, ping timing, RX capture, wrap, period, reset.
module tb_tof_ping_scheduler;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] time_cnt;
    logic [3:0]  rx_event;
    logic [7:0]  address;
    logic        write;
    logic [31:0] writedata;
    logic        read;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [3:0]  piezo_enable;
    logic        ping_done_irq;

    logic [31:0] cyc = 32'd0;
    logic [31:0] tc_off = 32'd0;
    int n_checks = 0;
    int n_errors = 0;

    assign time_cnt = cyc + tc_off;

    tof_ping_scheduler dut (
        .clock                    (clock),
        .reset                    (reset),
        .time_cnt                 (time_cnt),
        .rx_event                 (rx_event),
        .avalon_slave_address     (address),
        .avalon_slave_write       (write),
        .avalon_slave_writedata   (writedata),
        .avalon_slave_read        (read),
        .avalon_slave_readdata    (readdata),
        .avalon_slave_waitrequest (waitrequest),
        .piezo_enable             (piezo_enable),
        .ping_done_irq            (ping_done_irq)
    );

    always #10 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 32'd1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic av_write(input logic [7:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic av_read(input logic [7:0] a, output logic [31:0] d,
                           output logic w0, output logic w1);
        address = a;
        read    = 1'b1;
        #1 w0 = waitrequest;
        @(negedge clock);
        w1 = waitrequest;
        d  = readdata;
        @(negedge clock);
        read = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic w0, w1;
        av_read(a, d, w0, w1);
        chk(tag, d, exp);
    endtask

    task automatic wait_piezo();
        int k = 0;
        while (piezo_enable == 4'd0 && k < 5000) begin
            @(negedge clock);
            k++;
        end
        chk("piezo_rise_seen", 32'(piezo_enable != 4'd0), 32'd1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic w0, w1;
        int hi, k, nr;
        int rise_t [3];
        logic [3:0] rise_v [3];
        logic [3:0] prev;

        reset = 1'b1; rx_event = '0; address = '0; write = 1'b0; writedata = '0; read = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_piezo", 32'(piezo_enable), 32'd0);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_irq", 32'(ping_done_irq), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_waitreq", 32'(waitrequest), 32'd0);

        av_read(8'h04, d, w0, w1);
        chk("status_wait_first", 32'(w0), 32'd1);
        chk("status_wait_second", 32'(w1), 32'd0);
        chk("rst_status", d, 32'd0);
        rd_chk("unmapped_07", 8'h07, 32'hDEAD_BEEF);
        rd_chk("rst_timeout", 8'h03, 32'h0000_FFFF);
        rd_chk("rst_delta0", 8'h08, 32'hFFFF_FFFF);
        rd_chk("rst_ctrl", 8'h00, 32'd0);

        // Ping 1: all receivers arrive, rx0 re-toggles after capture.
        av_write(8'h01, 32'h1);
        av_write(8'h03, 32'd1000);
        av_write(8'h00, 32'h2);
        wait_piezo();
        chk("p1_tx", 32'(piezo_enable), 32'h1);
        hi = 0;
        for (int i = 0; i < 250; i++) begin
            if (piezo_enable != 4'd0) hi++;
            if (i == 100) rx_event[0] = 1'b1;
            if (i == 120) rx_event[0] = 1'b0;
            if (i == 130) rx_event[0] = 1'b1;
            if (i == 150) rx_event[2:1] = 2'b11;
            if (i == 200) rx_event[3] = 1'b1;
            @(negedge clock);
        end
        chk("p1_pulse_width", 32'(hi), 32'd16);
        rd_chk("p1_delta0", 8'h08, 32'd103);
        rd_chk("p1_delta1", 8'h09, 32'd153);
        rd_chk("p1_delta2", 8'h0A, 32'd153);
        rd_chk("p1_delta3", 8'h0B, 32'd203);
        rd_chk("p1_rx_valid", 8'h06, 32'hF);
        rd_chk("p1_status", 8'h04, 32'h0001_0000);
        rx_event = '0;

        // Ping 2: no arrivals, LISTEN must last TIMEOUT cycles.
        av_write(8'h03, 32'd500);
        av_write(8'h00, 32'h2);
        wait_piezo();
        k = 0;
        while (dut.state_q != 3'd5 && k < 2000) begin
            @(negedge clock);
            k++;
        end
        chk("p2_done_cycle", 32'(k), 32'd580);
        repeat (4) @(negedge clock);
        rd_chk("p2_rx_valid", 8'h06, 32'd0);
        rd_chk("p2_delta1", 8'h09, 32'hFFFF_FFFF);
        rd_chk("p2_status", 8'h04, 32'h0002_0000);
`ifdef TOF_SCHED_IRQ_EN
        chk("irq_set", 32'(ping_done_irq), 32'd1);
        av_write(8'h00, 32'h4);
        chk("irq_cleared", 32'(ping_done_irq), 32'd0);
`else
        chk("irq_tied_low", 32'(ping_done_irq), 32'd0);
`endif

        // Continuous run: tx1, tx3, tx1 every 2000 cycles.
        av_write(8'h01, 32'hA);
        av_write(8'h02, 32'd2000);
        av_write(8'h03, 32'd100);
        av_write(8'h00, 32'h1);
        nr = 0; k = 0; prev = '0;
        while (nr < 3 && k < 8000) begin
            if (prev == 4'd0 && piezo_enable != 4'd0) begin
                rise_t[nr] = k;
                rise_v[nr] = piezo_enable;
                nr++;
            end
            prev = piezo_enable;
            @(negedge clock);
            k++;
        end
        chk("run_rises", 32'(nr), 32'd3);
        chk("run_tx_a", 32'(rise_v[0]), 32'h2);
        chk("run_tx_b", 32'(rise_v[1]), 32'h8);
        chk("run_tx_c", 32'(rise_v[2]), 32'h2);
        chk("run_period_ab", 32'(rise_t[1] - rise_t[0]), 32'd2000);
        chk("run_period_bc", 32'(rise_t[2] - rise_t[1]), 32'd2000);
        av_write(8'h00, 32'h0);
        k = 0; d = 32'hFFFF_FFFF;
        while (d[2:0] != 3'd0 && k < 1500) begin
            av_read(8'h04, d, w0, w1);
            k++;
        end
        chk("run_stop_status", d, 32'h0005_0100);

        // Wrapping timestamp: EMIT_TIME lands on 0xFFFFFFF0, arrival +100 cycles -> delta 0x67.
        av_write(8'h01, 32'h1);
        av_write(8'h03, 32'd1000);
        tc_off = 32'hFFFF_FFEE - cyc;
        av_write(8'h00, 32'h2);
        wait_piezo();
        chk("wrap_tx0", 32'(piezo_enable), 32'h1);
        for (int i = 0; i < 130; i++) begin
            if (i == 40) rx_event[0] = 1'b1;
            if (i == 45) rx_event[0] = 1'b0;
            if (i == 100) rx_event = 4'hF;
            @(negedge clock);
        end
        rd_chk("wrap_emit_time", 8'h05, 32'hFFFF_FFF0);
        rd_chk("wrap_delta0", 8'h08, 32'h67);
        rd_chk("wrap_delta3", 8'h0B, 32'h67);
        rx_event = '0;

        // Reset during EMIT drops the pulse without waiting for a clock edge.
        av_write(8'h00, 32'h2);
        wait_piezo();
        repeat (5) @(negedge clock);
        #3 reset = 1'b1;
        #1 chk("rst_emit_piezo", 32'(piezo_enable), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_readdata", readdata, 32'd0);
        rd_chk("post_rst_status", 8'h04, 32'd0);
        rd_chk("post_rst_mask", 8'h01, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
